// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, byte/mode/state types and S-box arithmetic
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef logic [7:0] aes_byte_t;

    typedef enum logic {
        SB_FWD = 1'b0,
        SB_INV = 1'b1
    } sb_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } subbytes_state_e;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t acc;
        aes_byte_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires
    function automatic aes_byte_t gf_inv(input aes_byte_t x);
        aes_byte_t p;
        aes_byte_t r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic aes_byte_t rotl8(input aes_byte_t x, input int n);
        return aes_byte_t'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic aes_byte_t sbox_fwd(input aes_byte_t x);
        aes_byte_t v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic aes_byte_t sbox_inv(input aes_byte_t x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_subbytes_sbox_lane.sv
// rtl/aes_subbytes_sbox_lane.sv - one lookup lane: both tables on a shared address, mode-selected
module sbox_lane
    import aes_pkg::*;
(
    input  logic      i_clk,
    input  sb_mode_e  i_mode,
    input  aes_byte_t i_addr,
    output aes_byte_t o_data
);

    aes_byte_t fwd_data;
    aes_byte_t inv_data;

    sbox u_sbox (
        .i_clk  (i_clk),
        .i_addr (i_addr),
        .o_data (fwd_data)
    );

    inv_sbox u_inv_sbox (
        .i_clk  (i_clk),
        .i_addr (i_addr),
        .o_data (inv_data)
    );

    // Mode is held from accept to completion, so selecting after the register is safe.
    assign o_data = (i_mode == SB_INV) ? inv_data : fwd_data;

endmodule

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - registered inverse AES S-box, one cycle read latency
module inv_sbox
    import aes_pkg::*;
(
    input  logic      i_clk,
    input  aes_byte_t i_addr,
    output aes_byte_t o_data
);

    always_ff @(posedge i_clk) begin
        o_data <= sbox_inv(i_addr);
    end

endmodule

// File: rtl/sbox.sv
// rtl/sbox.sv - registered forward AES S-box, one cycle read latency
module sbox
    import aes_pkg::*;
(
    input  logic      i_clk,
    input  aes_byte_t i_addr,
    output aes_byte_t o_data
);

    always_ff @(posedge i_clk) begin
        o_data <= sbox_fwd(i_addr);
    end

endmodule

// File: rtl/aes_subbytes_seq.sv
// rtl/aes_subbytes_seq.sv - streams a 128-bit state through LANES S-box lanes and reassembles it
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_inv,
    input  logic [AES_BLOCK_W-1:0] i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AES_BLOCK_W-1:0] o_data
);

    localparam int G     = AES_NBYTES / LANES;
    localparam int CNT_W = (G > 1) ? $clog2(G) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(G - 1);

    subbytes_state_e state;
    subbytes_state_e state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cap_idx;
    logic             cap_pend;
    sb_mode_e         mode;
    logic             accept;
    logic             issue_last;
    logic [3:0]       issue_base;
    logic [3:0]       cap_base;

    aes_byte_t src [AES_NBYTES];
    aes_byte_t res [AES_NBYTES];
    aes_byte_t lane_out [LANES];

    assign o_ready    = (state == IDLE);
    assign o_valid    = (state == DONE);
    assign accept     = i_valid && o_ready;
    assign issue_last = (state == ISSUE) && (cnt == LAST_GRP);
    assign issue_base = 4'(int'(cnt) * LANES);
    assign cap_base   = 4'(int'(cap_idx) * LANES);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = ISSUE;
            ISSUE:   if (issue_last) state_nxt = DRAIN;
            DRAIN:                   state_nxt = DONE;
            DONE:    if (i_ready)    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Capture trails issue by one cycle to absorb the table register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            cap_idx  <= '0;
            cap_pend <= 1'b0;
            mode     <= SB_FWD;
            for (int b = 0; b < AES_NBYTES; b++) begin
                src[b] <= '0;
                res[b] <= '0;
            end
        end else begin
            cap_pend <= (state == ISSUE);
            cap_idx  <= cnt;
            if (accept) begin
                cnt  <= '0;
                mode <= i_inv ? SB_INV : SB_FWD;
                for (int b = 0; b < AES_NBYTES; b++) begin
                    src[b] <= i_data[AES_BLOCK_W-1-8*b -: 8];
                end
            end else if (state == ISSUE) begin
                cnt <= issue_last ? '0 : cnt + 1'b1;
            end
            if (cap_pend) begin
                for (int j = 0; j < LANES; j++) begin
                    res[cap_base + 4'(j)] <= lane_out[j];
                end
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        sbox_lane u_lane (
            .i_clk  (i_clk),
            .i_mode (mode),
            .i_addr (src[issue_base + 4'(j)]),
            .o_data (lane_out[j])
        );
    end

    for (genvar b = 0; b < AES_NBYTES; b++) begin : g_out
        assign o_data[AES_BLOCK_W-1-8*b -: 8] = res[b];
    end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// tb/tb_aes_subbytes_seq.sv - self-checking bench for aes_subbytes_seq across LANES 1/4/16
module tb_aes_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         i_inv;
    logic         i_ready;
    logic [127:0] i_data;

    logic         o_ready4, o_valid4, o_ready1, o_valid1, o_ready16, o_valid16;
    logic [127:0] o_data4, o_data1, o_data16;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct {
        logic [127:0] d;
        logic         inv;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    aes_subbytes_seq #(.LANES(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready4), .i_inv(i_inv),
        .i_data(i_data), .o_valid(o_valid4), .i_ready(i_ready), .o_data(o_data4)
    );

    aes_subbytes_seq #(.LANES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready1), .i_inv(i_inv),
        .i_data(i_data), .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1)
    );

    aes_subbytes_seq #(.LANES(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready16), .i_inv(i_inv),
        .i_data(i_data), .o_valid(o_valid16), .i_ready(i_ready), .o_data(o_data16)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Polynomial product, then reduction by the AES modulus
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] v, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++) if (x != 0 && ref_mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = d[127-8*k -: 8];
            r[127-8*k -: 8] = inv ? isb[b] : sb[b];
        end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_inv = 1'b0; i_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction on the LANES=4 instance with optional backpressure in DONE
    task automatic txn4(input logic [127:0] d, input logic inv, input logic [127:0] exp,
                        input int hold, input string tag);
        int t;
        int lat;
        @(negedge clk);
        t = 0;
        while (!o_ready4 && t < 50) begin @(negedge clk); t++; end
        chk({tag, " ready_before"}, 128'(o_ready4), 128'd1);
        i_valid = 1'b1; i_data = d; i_inv = inv; i_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!o_valid4 && lat < 100) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            i_inv   = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 128'(lat), 128'd5);
        chk({tag, " data"}, o_data4, exp);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk({tag, " hold"}, {o_valid4, o_ready4, o_data4}, {1'b1, 1'b0, exp});
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        chk({tag, " released"}, {126'd0, o_valid4, o_ready4}, 128'b01);
    endtask

    // Same state into all three instances at once; compare data and latency per width
    task automatic sweep(input logic [127:0] d, input logic inv, input string tag);
        logic [127:0] exp, r1, r4, r16;
        int  l1, l4, l16;
        bit  g1, g4, g16;
        exp = model_sub(d, inv);
        l1 = -1; l4 = -1; l16 = -1; g1 = 0; g4 = 0; g16 = 0;
        r1 = 'x; r4 = 'x; r16 = 'x;
        @(negedge clk);
        chk({tag, " all_ready"}, {125'd0, o_ready1, o_ready4, o_ready16}, 128'b111);
        i_valid = 1'b1; i_data = d; i_inv = inv; i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        for (int n = 0; n < 40 && !(g1 && g4 && g16); n++) begin
            if (o_valid1 && !g1)   begin g1 = 1;  l1 = n;  r1 = o_data1;  end
            if (o_valid4 && !g4)   begin g4 = 1;  l4 = n;  r4 = o_data4;  end
            if (o_valid16 && !g16) begin g16 = 1; l16 = n; r16 = o_data16; end
            @(negedge clk);
        end
        chk({tag, " lanes1 latency"}, 128'(l1), 128'd17);
        chk({tag, " lanes4 latency"}, 128'(l4), 128'd5);
        chk({tag, " lanes16 latency"}, 128'(l16), 128'd2);
        chk({tag, " lanes1 data"}, r1, exp);
        chk({tag, " lanes4 data"}, r4, exp);
        chk({tag, " lanes16 data"}, r16, exp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [127:0] qd [$];
        int           qc [$];
        int           acc_c [$];
        int           acc, got;
        bit           will_acc;
        logic [127:0] a, b, d;
        logic         inv;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 0};
        vecs[1] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, 0};
        vecs[2] = '{128'h0, 1'b0, {16{8'h63}}, 10};
        vecs[3] = '{{16{8'hff}}, 1'b0, {16{8'h16}}, 2};
        vecs[4] = '{{16{8'h63}}, 1'b1, 128'h0, 0};
        vecs[5] = '{{16{8'h53}}, 1'b0, {16{8'hed}}, 1};

        build_tables();

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_inv = 1'b0; i_data = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {o_valid4, o_ready4, o_data4}, {1'b0, 1'b1, 128'h0});
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset idle", {o_valid4, o_ready4, o_data4}, {1'b0, 1'b1, 128'h0});

        for (int i = 0; i < 6; i++)
            txn4(vecs[i].d, vecs[i].inv, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));

        // Back-to-back with i_valid held and no backpressure
        a = vecs[0].d; b = {$urandom, $urandom, $urandom, $urandom};
        i_ready = 1'b1; i_valid = 1'b1; i_data = a; i_inv = 1'b0;
        acc = 0; got = 0;
        @(negedge clk);
        for (int c = 0; c < 60 && got < 2; c++) begin
            will_acc = o_ready4 && i_valid;
            if (will_acc) acc_c.push_back(c);
            if (o_valid4) begin qd.push_back(o_data4); qc.push_back(c); got++; end
            @(negedge clk);
            if (will_acc) begin
                acc++;
                if (acc == 1) i_data = b; else i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        chk("b2b count", 128'(got), 128'd2);
        if (got == 2 && acc_c.size() >= 2) begin
            chk("b2b first", qd[0], model_sub(a, 1'b0));
            chk("b2b second", qd[1], model_sub(b, 1'b0));
            chk("b2b first latency", 128'(qc[0] - acc_c[0]), 128'd6);
            chk("b2b second latency", 128'(qc[1] - acc_c[1]), 128'd6);
        end

        // Asynchronous reset after group 1 has been issued
        @(negedge clk);
        i_valid = 1'b1; i_data = vecs[0].d; i_inv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mid-issue reset", {o_valid4, o_ready4, o_data4}, {1'b0, 1'b1, 128'h0});
        @(negedge clk);
        rst_n = 1'b1;
        txn4(vecs[2].d, 1'b0, vecs[2].exp, 0, "after_reset");

        for (int i = 0; i < 30; i++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            txn4(d, inv, model_sub(d, inv), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        do_reset();
        sweep(vecs[0].d, 1'b0, "sweep_vec0");
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            sweep(d, 1'($urandom_range(0, 1)), $sformatf("sweep_rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
